enable_register: RTL and testbench

Parameterised D-type storage register with synchronous load enable and asynchronous active-high reset. On each rising clock edge it captures the input word when the enable is asserted and holds its contents otherwise. It is a general-purpose pipeline/holding element for datapaths that need a qualified load. The default build is 8 bits wide.

---
 rtl/enable_register.sv | 44 ++++
 tb/tb_enable_register.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/enable_register.sv
// enable_register: a WIDTH-bit D register with a synchronous load enable and
// an asynchronous active-high reset. The rstn port keeps its historical name,
// but a 1 on it asserts reset.
module enable_register #(
    parameter int unsigned          WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // Reject widths outside 1..64 when the design is elaborated.
    generate
        if (WIDTH < 1 || WIDTH > 64) begin : gWidthCheck
            $error("enable_register: WIDTH must be in 1..64");
        end
    endgenerate

    logic [WIDTH-1:0] storage_q;
    logic [WIDTH-1:0] storage_d;

    // Next state: take the whole input word when enabled, otherwise hold.
    always_comb begin
        storage_d = storage_q;
        if (en) begin
            storage_d = data;
        end
    end

    // State register: reset acts at once, and loads happen only on the clock edge.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            storage_q <= RESET_VALUE;
        end else begin
            storage_q <= storage_d;
        end
    end

    assign q = storage_q;

endmodule

// File: tb/tb_enable_register.sv
// tb_enable_register: directed scoreboard bench for enable_register (8-bit default).
// The bench drives inputs on the falling edge. For each cycle it pushes the
// expected q into a queue. It pops and compares that value 1 ns after the next
// rising edge.
module tb_enable_register;

    logic       clk;
    logic       rstn;
    logic [7:0] data;
    logic       en;
    logic [7:0] q;

    logic [7:0] expQ;
    logic [7:0] sbQ[$];
    int         passCount;
    int         checkCount;

    enable_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk  (clk),
        .rstn (rstn),
        .data (data),
        .en   (en),
        .q    (q)
    );

    // Free-running clock, 10 ns period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs on the falling edge and queue the value q must show after the next rising edge.
    task automatic applyStimulus(input logic [7:0] d, input logic e, input logic r);
        @(negedge clk);
        data = d;
        en   = e;
        rstn = r;
        if (r) begin
            expQ = 8'h00;
        end else if (e) begin
            expQ = d;
        end
        sbQ.push_back(expQ);
    endtask

    // Compare q against a value the bench supplies, at the current time.
    task automatic checkNow(input string tag, input logic [7:0] want);
        checkCount++;
        assert (q === want) passCount++;
        else $error("[TB] FAIL %s: q=%h expected %h", tag, q, want);
    endtask

    // Wait for the rising edge, then pop the queued expectation and compare it against q.
    task automatic checkOutput(input string tag);
        logic [7:0] want;
        @(posedge clk);
        #1;
        if (sbQ.size() == 0) begin
            checkCount++;
            $error("[TB] FAIL %s: scoreboard empty, q=%h expected a queued value", tag, q);
        end else begin
            want = sbQ.pop_front();
            checkNow(tag, want);
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        expQ       = 8'h00;

        // Reset is asserted from time 0, with load-looking inputs present.
        rstn = 1'b1;
        data = 8'hFF;
        en   = 1'b1;
        #1;
        checkNow("resetInitial", 8'h00);

        // Hold reset for 3 cycles while en=1 and data=FF. q must stay 00.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hFF, 1'b1, 1'b1);
            checkOutput($sformatf("resetHold%0d", i));
        end

        // Release reset. The first edge afterwards loads FF.
        applyStimulus(8'hFF, 1'b1, 1'b0);
        checkOutput("resetRelease");

        // Basic loads.
        applyStimulus(8'hFD, 1'b1, 1'b0);
        checkOutput("loadFD");
        applyStimulus(8'h01, 1'b1, 1'b0);
        checkOutput("load01");

        // Tracking: q follows data one cycle later.
        applyStimulus(8'hEE, 1'b1, 1'b0);
        checkOutput("trackEE");
        applyStimulus(8'h82, 1'b1, 1'b0);
        checkOutput("track82");
        applyStimulus(8'hD4, 1'b1, 1'b0);
        checkOutput("trackD4");

        // Mid-cycle change: 82 is replaced by 77 before the edge, so only 77 is captured.
        data = 8'h82;
        en   = 1'b1;
        #3;
        data = 8'h77;
        expQ = 8'h77;
        sbQ.push_back(expQ);
        checkOutput("midCycle77");

        // Load A5, then hold it through 4 cycles of en=0 with changing or unknown data.
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkOutput("loadA5");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkOutput("hold3C");
        applyStimulus(8'hFF, 1'b0, 1'b0);
        checkOutput("holdFF");
        applyStimulus(8'hxx, 1'b0, 1'b0);
        checkOutput("holdXX");
        applyStimulus(8'h5A, 1'b0, 1'b0);
        checkOutput("hold5A");

        // Reload D4 before the asynchronous reset test.
        applyStimulus(8'hD4, 1'b1, 1'b0);
        checkOutput("loadD4");

        // Pulse reset for 2 ns between edges. q must clear at once, without a clock edge.
        en = 1'b0;
        #1;
        rstn = 1'b1;
        #1;
        expQ = 8'h00;
        checkNow("asyncRstMid", 8'h00);
        #1;
        rstn = 1'b0;

        // After release, q stays 00 until an enabled edge.
        applyStimulus(8'h55, 1'b0, 1'b0);
        checkOutput("postRstHold");
        applyStimulus(8'h55, 1'b1, 1'b0);
        checkOutput("postRstLoad55");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
